uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among N_REQ byte producers.
// Optional REQ-state abort timer enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ = 4
`ifdef UART_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 16384
`endif
) (
  input  logic                       clk_50M,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [8*N_REQ-1:0]         req_data,
  output logic [N_REQ-1:0]           grant,
  input  logic                       uart_busy,
  output logic                       uart_write_en,
  output logic [7:0]                 uart_write_data,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       active,
  output logic                       timeout_err
);

  localparam int unsigned OW = $clog2(N_REQ);
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic            wen_q, wen_d;
  logic [DW-1:0]   data_q, data_d;
  logic            active_q, active_d;
  logic [OW-1:0]   win;
  logic [DW-1:0]   win_data;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CW = 15;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            terr_q, terr_d;
`endif

  // First requester at or above start, wrapping past N_REQ-1.
  function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [OW-1:0]    start);
    logic [OW-1:0] w;
    logic [OW-1:0] idx;
    logic          found;
    w     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = OW'((32'(start) + i) % N_REQ);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // Winner selection and its byte.
  always_comb begin
    win      = rr_pick(req, ptr_q);
    win_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win == OW'(i)) win_data = req_data[8*i +: 8];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = '0;
    wen_d   = wen_q;
    data_d  = data_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    terr_d  = terr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!uart_busy && |req) begin
          owner_d = win;
          ptr_d   = OW'((32'(win) + 1) % N_REQ);
          grant_d = N_REQ'(1) << win;
          wen_d   = 1'b1;
          data_d  = win_data;
          state_d = S_REQ;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_REQ: begin
        if (uart_busy) begin
          wen_d   = 1'b0;
          state_d = S_DRAIN;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          // Transmitter never acknowledged: drop the byte and re-arbitrate.
          wen_d   = 1'b0;
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
`endif
      end
      S_DRAIN: begin
        if (!uart_busy) state_d = S_IDLE;
      end
      default: begin
        wen_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      wen_q    <= 1'b0;
      data_q   <= '0;
      active_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      terr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      wen_q    <= wen_d;
      data_q   <= data_d;
      active_q <= active_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      terr_q   <= terr_d;
`endif
    end
  end

  assign grant           = grant_q;
  assign uart_write_en   = wen_q;
  assign uart_write_data = data_q;
  assign owner           = owner_q;
  assign active          = active_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_err     = terr_q;
`else
  assign timeout_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a small UART busy-handshake stub.
// Build with UART_ARB_TIMEOUT_EN defined to exercise the abort timer (TIMEOUT_CYC=100).
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  logic          clk_50M = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] grant;
  wire           uart_busy;
  logic          uart_write_en;
  logic [7:0]    uart_write_data;
  logic [1:0]    owner;
  logic          active;
  logic          timeout_err;

  logic force_hi  = 1'b0;
  logic stub_on   = 1'b0;
  logic stub_busy = 1'b0;
  int   stub_cnt  = 0;
  int   ack_dly   = 3;
  int   frame_len = 20;

  exp_t       exp_q[$];
  int         g_obs[$];
  logic [7:0] d_obs[$];
  int         viol = 0;
  logic       wen_prev = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #10 clk_50M = ~clk_50M;

  assign uart_busy = force_hi | (stub_on & stub_busy);

  uart_tx_arbiter #(
    .N_REQ(NR)
`ifdef UART_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(100)
`endif
  ) dut (
    .clk_50M        (clk_50M),
    .rst            (rst),
    .req            (req),
    .req_data       (req_data),
    .grant          (grant),
    .uart_busy      (uart_busy),
    .uart_write_en  (uart_write_en),
    .uart_write_data(uart_write_data),
    .owner          (owner),
    .active         (active),
    .timeout_err    (timeout_err)
  );

  // UART stub: acknowledges write_en after ack_dly cycles, stays busy for frame_len cycles.
  always @(posedge clk_50M) begin
    if (!stub_on) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
    end else if (!stub_busy) begin
      if (uart_write_en) begin
        if (stub_cnt >= ack_dly) begin
          stub_busy <= 1'b1;
          stub_cnt  <= 0;
          d_obs.push_back(uart_write_data);
        end else begin
          stub_cnt <= stub_cnt + 1;
        end
      end else begin
        stub_cnt <= 0;
      end
    end else if (stub_cnt >= frame_len - 1) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
    end else begin
      stub_cnt <= stub_cnt + 1;
    end
  end

  // Grant monitor: records winners and flags illegal grant pulses.
  always @(negedge clk_50M) begin
    if (grant != '0) begin
      if (!$onehot(grant) || wen_prev || !uart_write_en) viol++;
      for (int i = 0; i < NR; i++) if (grant[i]) g_obs.push_back(i);
    end
    wen_prev = uart_write_en;
  end

  task automatic wait_frames(input int n, output bit ok);
    int b = 0;
    while (d_obs.size() < n && b < 5000) begin
      @(negedge clk_50M);
      b++;
    end
    ok = (d_obs.size() >= n);
  endtask

  task automatic wait_idle(output bit ok);
    int b = 0;
    while (active !== 1'b0 && b < 5000) begin
      @(negedge clk_50M);
      b++;
    end
    ok = (active === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_data = '0;
    repeat (3) @(negedge clk_50M);
    checks++; if (grant !== 4'b0) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (uart_write_en !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", uart_write_en); end
    checks++; if (uart_write_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", uart_write_data); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", active); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_terr got=%b exp=0", timeout_err); end
    rst = 1'b0;
    @(negedge clk_50M);
  endtask

  task automatic test_single();
    bit ok;
    stub_on = 1'b1; ack_dly = 3;
    req_data[15:8] = 8'hA5; req = 4'b0010;
    exp_q.push_back('{idx: 2'd1, data: 8'hA5});
    @(negedge clk_50M);
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL single_grant got=%b exp=0010", grant); end
    checks++; if (uart_write_en !== 1'b1) begin failures++; $display("FAIL single_wen got=%b exp=1", uart_write_en); end
    checks++; if (uart_write_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", uart_write_data); end
    checks++; if (owner !== 2'd1) begin failures++; $display("FAIL single_owner got=%0d exp=1", owner); end
    req = '0;
    @(negedge clk_50M);
    checks++; if (grant !== 4'b0) begin failures++; $display("FAIL single_pulse got=%b exp=0000", grant); end
    checks++; if (uart_write_en !== 1'b1) begin failures++; $display("FAIL single_hold got=%b exp=1", uart_write_en); end
    wait_frames(1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_ack_timeout got=%0d frames exp=1", d_obs.size()); end
    @(negedge clk_50M);
    checks++; if (uart_write_en !== 1'b0) begin failures++; $display("FAIL single_wen_drop got=%b exp=0", uart_write_en); end
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL single_drain got=%b exp=1", active); end
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_idle got=%b exp=0", active); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int base, gbase;
    rst = 1'b1; @(negedge clk_50M); rst = 1'b0;
    base = d_obs.size(); gbase = g_obs.size();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 5; i++) exp_q.push_back('{idx: 2'(i % 4), data: 8'(8'h10 + (i % 4))});
    req = 4'hF;
    wait_frames(base + 5, ok);
    req = '0;
    checks++; if (!ok) begin failures++; $display("FAIL rr_frames got=%0d exp=%0d", d_obs.size() - base, 5); end
    wait_idle(ok);
    checks++; if (!ok || (g_obs.size() - gbase) != 5) begin failures++; $display("FAIL rr_grant_count got=%0d exp=5", g_obs.size() - gbase); end
  endtask

  task automatic test_busy_idle();
    bit ok;
    int gb;
    stub_on = 1'b0; force_hi = 1'b1;
    gb = g_obs.size();
    req_data[7:0] = 8'h5C; req = 4'b0001;
    repeat (20) @(negedge clk_50M);
    checks++; if (g_obs.size() != gb) begin failures++; $display("FAIL busy_nogrant got=%0d exp=%0d", g_obs.size(), gb); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL busy_active got=%b exp=0", active); end
    force_hi = 1'b0;
    @(negedge clk_50M);
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL busy_grant got=%b exp=0001", grant); end
    checks++; if (uart_write_data !== 8'h5C) begin failures++; $display("FAIL busy_data got=%h exp=5c", uart_write_data); end
    req = '0;
    exp_q.push_back('{idx: 2'd0, data: 8'h5C});
    stub_on = 1'b1;
    wait_frames(d_obs.size() + 1, ok);
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL busy_idle got=%b exp=0", active); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int gb, base, gi;
    ack_dly = 50;
    gb = g_obs.size();
    req_data[23:16] = 8'h3C; req = 4'b0100;
    @(negedge clk_50M);
    checks++; if (uart_write_en !== 1'b1) begin failures++; $display("FAIL rmid_wen got=%b exp=1", uart_write_en); end
    req = '0;
    repeat (5) @(negedge clk_50M);
    rst = 1'b1;
    @(negedge clk_50M);
    rst = 1'b0;
    checks++; if (uart_write_en !== 1'b0) begin failures++; $display("FAIL rmid_wen_drop got=%b exp=0", uart_write_en); end
    checks++; if (uart_write_data !== 8'h00) begin failures++; $display("FAIL rmid_data got=%h exp=00", uart_write_data); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL rmid_owner got=%0d exp=0", owner); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL rmid_active got=%b exp=0", active); end
    gi = (g_obs.size() == gb + 1) ? g_obs.pop_back() : -1;
    checks++; if (gi != 2) begin failures++; $display("FAIL rmid_aborted_grant got=%0d exp=2", gi); end
    // Pointer restarts at 0, so requester 2 beats requester 3.
    ack_dly = 3;
    base = d_obs.size();
    req_data[31:24] = 8'hC3; req = 4'b1100;
    exp_q.push_back('{idx: 2'd2, data: 8'h3C});
    exp_q.push_back('{idx: 2'd3, data: 8'hC3});
    @(negedge clk_50M);
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL rmid_regrant got=%b exp=0100", grant); end
    req = 4'b1000;
    wait_frames(base + 2, ok);
    req = '0;
    checks++; if (!ok) begin failures++; $display("FAIL rmid_frames got=%0d exp=2", d_obs.size() - base); end
    wait_idle(ok);
  endtask

  task automatic test_timeout();
    bit ok;
    int gb, cnt, gi;
    stub_on = 1'b0; force_hi = 1'b0;
    gb = g_obs.size();
    req_data[7:0] = 8'hE1; req_data[15:8] = 8'hE2; req = 4'b0011;
    @(negedge clk_50M);
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL to_grant0 got=%b exp=0001", grant); end
    req = 4'b0010;
    cnt = 0;
    while (uart_write_en === 1'b1 && cnt < 400) begin
      cnt++;
      @(negedge clk_50M);
    end
`ifdef UART_ARB_TIMEOUT_EN
    checks++; if (cnt != 100) begin failures++; $display("FAIL to_wen_cycles got=%0d exp=100", cnt); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", timeout_err); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL to_active got=%b exp=0", active); end
    @(negedge clk_50M);
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL to_next_grant got=%b exp=0010", grant); end
    req = '0;
    gi = (g_obs.size() > gb) ? g_obs[gb] : -1;
    checks++; if (gi != 0) begin failures++; $display("FAIL to_aborted_grant got=%0d exp=0", gi); end
    if (g_obs.size() > gb) g_obs.delete(gb);
    exp_q.push_back('{idx: 2'd1, data: 8'hE2});
    stub_on = 1'b1;
    wait_frames(d_obs.size() + 1, ok);
    wait_idle(ok);
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%b exp=1", timeout_err); end
`else
    checks++; if (cnt != 400) begin failures++; $display("FAIL noto_wen_cycles got=%0d exp=400", cnt); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL noto_err got=%b exp=0", timeout_err); end
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL noto_active got=%b exp=1", active); end
    exp_q.push_back('{idx: 2'd0, data: 8'hE1});
    exp_q.push_back('{idx: 2'd1, data: 8'hE2});
    gi = d_obs.size();
    stub_on = 1'b1;
    wait_frames(gi + 2, ok);
    req = '0;
    checks++; if (!ok) begin failures++; $display("FAIL noto_frames got=%0d exp=2", d_obs.size() - gi); end
    wait_idle(ok);
`endif
  endtask

  task automatic test_scoreboard();
    exp_t       e;
    int         gi;
    logic [7:0] d;
    checks++;
    if (exp_q.size() != d_obs.size() || exp_q.size() != g_obs.size()) begin
      failures++;
      $display("FAIL sb_count got=%0d/%0d exp=%0d", g_obs.size(), d_obs.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && d_obs.size() != 0 && g_obs.size() != 0) begin
      e  = exp_q.pop_front();
      gi = g_obs.pop_front();
      d  = d_obs.pop_front();
      checks++; if (gi != int'(e.idx)) begin failures++; $display("FAIL sb_grant got=%0d exp=%0d", gi, e.idx); end
      checks++; if (d !== e.data) begin failures++; $display("FAIL sb_data got=%h exp=%h", d, e.data); end
    end
    checks++; if (viol != 0) begin failures++; $display("FAIL grant_protocol got=%0d exp=0", viol); end
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_busy_idle();
    test_reset_mid();
    test_timeout();
    test_scoreboard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
